// File: rtl/mem_access.sv
// rv32i memory-access stage: issues dmem transactions, extracts
// load data and registers the MEM/WB bundle for write_back.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_data,
  input  logic [31:0] pc_address_in,
  input  logic [31:0] u_imm_in,
  input  logic        jal,
  input  logic        jalr,
  input  logic        lui,
  input  logic        reg_write,
  input  logic [4:0]  rd_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mask,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        wb_valid,
  output logic        wb_load,
  output logic        wb_jal,
  output logic        wb_jalr,
  output logic        wb_lui,
  output logic        wb_reg_write,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_byte_accessL,
  output logic [31:0] wb_pc_address_out,
  output logic [31:0] wb_u_imm,
  output logic [4:0]  wb_rd_addr
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [1:0]  off;
  logic        mem_op;
  logic        bad;
  logic        accept;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        ld_q;
  logic [31:0] alu_q;
  logic [31:0] pc_q;
  logic [31:0] uimm_q;
  logic        jal_q;
  logic        jalr_q;
  logic        lui_q;
  logic        rw_q;
  logic [4:0]  rd_q;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ext;

  assign off    = alu_out[1:0];
  assign mem_op = load | store;
  assign accept = ex_valid & mem_op & ~bad;

  always_comb begin
    bad = 1'b0;
    unique case (funct3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = off[0];
      3'b010:         bad = |off;
      default:        bad = 1'b1;
    endcase
  end

  always_comb begin
    mask  = 4'b1111;
    wdata = rs2_data;
    if (store) begin
      unique case (funct3[1:0])
        2'b00: begin
          mask  = 4'b0001 << off;
          wdata = {4{rs2_data[7:0]}};
        end
        2'b01: begin
          mask  = off[1] ? 4'b1100 : 4'b0011;
          wdata = {2{rs2_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bsel = dmem_rdata[{off_q, 3'b000} +: 8];
    hsel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (f3_q)
      3'b000:  ext = {{24{bsel[7]}}, bsel};
      3'b100:  ext = {24'b0, bsel};
      3'b001:  ext = {{16{hsel[15]}}, hsel};
      3'b101:  ext = {16'b0, hsel};
      default: ext = dmem_rdata;
    endcase
    if (dmem_we) ext = 32'b0;
  end

  assign dmem_req  = (state == BUSY);
  assign dmem_addr = {alu_q[31:2], 2'b00};
  // gated with rst so stall reads 0 for the whole reset window
  assign stall = rst & ((state == IDLE) ? accept : ~dmem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      f3_q              <= 3'b0;
      off_q             <= 2'b0;
      ld_q              <= 1'b0;
      alu_q             <= 32'b0;
      pc_q              <= 32'b0;
      uimm_q            <= 32'b0;
      jal_q             <= 1'b0;
      jalr_q            <= 1'b0;
      lui_q             <= 1'b0;
      rw_q              <= 1'b0;
      rd_q              <= 5'b0;
      dmem_we           <= 1'b0;
      dmem_wdata        <= 32'b0;
      dmem_mask         <= 4'b0;
      misaligned        <= 1'b0;
      wb_valid          <= 1'b0;
      wb_load           <= 1'b0;
      wb_jal            <= 1'b0;
      wb_jalr           <= 1'b0;
      wb_lui            <= 1'b0;
      wb_reg_write      <= 1'b0;
      wb_alu_out        <= 32'b0;
      wb_byte_accessL   <= 32'b0;
      wb_pc_address_out <= 32'b0;
      wb_u_imm          <= 32'b0;
      wb_rd_addr        <= 5'b0;
    end else begin
      misaligned <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state      <= BUSY;
            f3_q       <= funct3;
            off_q      <= off;
            ld_q       <= load;
            alu_q      <= alu_out;
            pc_q       <= pc_address_in;
            uimm_q     <= u_imm_in;
            jal_q      <= jal;
            jalr_q     <= jalr;
            lui_q      <= lui;
            rw_q       <= reg_write & ~store;
            rd_q       <= rd_addr;
            dmem_we    <= store;
            dmem_wdata <= wdata;
            dmem_mask  <= mask;
            wb_valid   <= 1'b0;
          end else begin
            wb_valid          <= ex_valid;
            wb_load           <= load;
            wb_jal            <= jal;
            wb_jalr           <= jalr;
            wb_lui            <= lui;
            wb_alu_out        <= alu_out;
            wb_byte_accessL   <= 32'b0;
            wb_pc_address_out <= pc_address_in;
            wb_u_imm          <= u_imm_in;
            wb_rd_addr        <= rd_addr;
            wb_reg_write      <= reg_write & ~(mem_op & ex_valid);
            misaligned        <= ex_valid & mem_op;
          end
        end
        BUSY: begin
          if (dmem_ready) begin
            state             <= IDLE;
            wb_valid          <= 1'b1;
            wb_load           <= ld_q;
            wb_jal            <= jal_q;
            wb_jalr           <= jalr_q;
            wb_lui            <= lui_q;
            wb_reg_write      <= rw_q;
            wb_alu_out        <= alu_q;
            wb_byte_accessL   <= ext;
            wb_pc_address_out <= pc_q;
            wb_u_imm          <= uimm_q;
            wb_rd_addr        <= rd_q;
          end else begin
            wb_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus a
// randomized sweep against a width/offset arithmetic model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        load = 1'b0;
  logic        store = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] alu_out = 32'b0;
  logic [31:0] rs2_data = 32'b0;
  logic [31:0] pc_address_in = 32'b0;
  logic [31:0] u_imm_in = 32'b0;
  logic        jal = 1'b0;
  logic        jalr = 1'b0;
  logic        lui = 1'b0;
  logic        reg_write = 1'b0;
  logic [4:0]  rd_addr = 5'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mask;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = 32'b0;
  logic        stall;
  logic        misaligned;
  logic        wb_valid;
  logic        wb_load;
  logic        wb_jal;
  logic        wb_jalr;
  logic        wb_lui;
  logic        wb_reg_write;
  logic [31:0] wb_alu_out;
  logic [31:0] wb_byte_accessL;
  logic [31:0] wb_pc_address_out;
  logic [31:0] wb_u_imm;
  logic [4:0]  wb_rd_addr;

  int errors = 0;
  int checks = 0;

  mem_access dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid),
    .load(load), .store(store), .funct3(funct3),
    .alu_out(alu_out), .rs2_data(rs2_data),
    .pc_address_in(pc_address_in), .u_imm_in(u_imm_in),
    .jal(jal), .jalr(jalr), .lui(lui),
    .reg_write(reg_write), .rd_addr(rd_addr),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_mask(dmem_mask), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall(stall),
    .misaligned(misaligned), .wb_valid(wb_valid),
    .wb_load(wb_load), .wb_jal(wb_jal), .wb_jalr(wb_jalr),
    .wb_lui(wb_lui), .wb_reg_write(wb_reg_write),
    .wb_alu_out(wb_alu_out), .wb_byte_accessL(wb_byte_accessL),
    .wb_pc_address_out(wb_pc_address_out), .wb_u_imm(wb_u_imm),
    .wb_rd_addr(wb_rd_addr)
  );

  always #5 clk = ~clk;

  function automatic int size_of(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit legal(input logic [2:0] f, input logic [31:0] a);
    if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b0;
    return (a % size_of(f)) == 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f,
      input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    int sz;
    sz = size_of(f);
    if (sz == 4) return w;
    v = (w >> (8 * (a % 4))) % (1 << (8 * sz));
    if (f[2] == 1'b0 && v >= (1 << (8 * sz - 1)))
      v = v + (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [2:0] f,
      input logic [31:0] a);
    logic [3:0] m;
    m = 4'b0;
    for (int i = 0; i < 4; i++)
      if (i >= a % 4 && i < a % 4 + size_of(f)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f,
      input logic [31:0] d);
    logic [31:0] r;
    r = 32'b0;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = d[8 * (i % size_of(f)) +: 8];
    return r;
  endfunction

  // kind: 0 = non-memory, 1 = load, 2 = store
  task automatic run_op(input int kind, input logic [2:0] f,
      input logic [31:0] a, input logic [31:0] d,
      input logic [31:0] rdata, input int waits,
      input logic [4:0] rd, input logic rw);
    logic [31:0] pc;
    logic [31:0] ui;
    bit mem;
    bit ok;
    int stalls;
    logic [3:0] m;
    logic [31:0] lv;
    pc = $urandom;
    ui = $urandom;
    mem = (kind != 0);
    ok = mem ? legal(f, a) : 1'b1;
    m = (kind == 2) ? exp_mask(f, a) : 4'b1111;
    lv = (kind == 1) ? exp_load(f, a, rdata) : 32'b0;
    stalls = 0;
    @(negedge clk);
    ex_valid = 1'b1;
    load = (kind == 1);
    store = (kind == 2);
    funct3 = f;
    alu_out = a;
    rs2_data = d;
    pc_address_in = pc;
    u_imm_in = ui;
    reg_write = rw;
    rd_addr = rd;
    jal = 1'b0;
    jalr = 1'b0;
    lui = 1'b0;
    dmem_ready = mem ? 1'b0 : 1'($urandom);
    #1;
    checks++;
    if (stall !== (mem && ok)) begin
      errors++;
      $display("FAIL accept_stall got %b want %b", stall, mem && ok);
    end
    if (stall) stalls++;
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL accept_req got %b want 0", dmem_req);
    end
    @(negedge clk);
    ex_valid = 1'b0;
    load = 1'b0;
    store = 1'b0;
    dmem_ready = 1'b0;
    #1;
    if (!mem || !ok) begin
      checks++;
      if (wb_valid !== 1'b1 || wb_alu_out !== a || wb_rd_addr !== rd) begin
        errors++;
        $display("FAIL pass_wb got v=%b a=%h rd=%0d want 1 %h %0d",
                 wb_valid, wb_alu_out, wb_rd_addr, a, rd);
      end
      checks++;
      if (wb_reg_write !== (rw && !mem) || misaligned !== !ok) begin
        errors++;
        $display("FAIL pass_flags got rw=%b mis=%b want %b %b",
                 wb_reg_write, misaligned, rw && !mem, !ok);
      end
      checks++;
      if (dmem_req !== 1'b0 || wb_byte_accessL !== 32'b0) begin
        errors++;
        $display("FAIL pass_req got req=%b bal=%h want 0 0",
                 dmem_req, wb_byte_accessL);
      end
      @(negedge clk);
      #1;
      checks++;
      if (misaligned !== 1'b0 || wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL pass_after got mis=%b v=%b want 0 0",
                 misaligned, wb_valid);
      end
      return;
    end
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL bubble got %b want 0", wb_valid);
    end
    for (int w = 0; w <= waits; w++) begin
      if (w == waits) begin
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
      end
      #1;
      if (stall) stalls++;
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== (kind == 2) ||
          dmem_addr !== (a & ~32'd3) || dmem_mask !== m) begin
        errors++;
        $display("FAIL req_fields got r=%b we=%b a=%h m=%b want 1 %b %h %b",
                 dmem_req, dmem_we, dmem_addr, dmem_mask,
                 kind == 2, a & ~32'd3, m);
      end
      if (kind == 2) begin
        checks++;
        if (dmem_wdata !== exp_wdata(f, d)) begin
          errors++;
          $display("FAIL wdata got %h want %h", dmem_wdata, exp_wdata(f, d));
        end
      end
      checks++;
      if (stall !== (w != waits) || (w != 0 && wb_valid !== 1'b0)) begin
        errors++;
        $display("FAIL busy got stall=%b v=%b want %b 0",
                 stall, wb_valid, w != waits);
      end
      @(negedge clk);
    end
    dmem_ready = 1'b0;
    dmem_rdata = $urandom;
    #1;
    checks++;
    if (stalls !== waits + 1) begin
      errors++;
      $display("FAIL stall_cycles got %0d want %0d", stalls, waits + 1);
    end
    checks++;
    if (wb_valid !== 1'b1 || wb_byte_accessL !== lv) begin
      errors++;
      $display("FAIL wb_data got v=%b bal=%h want 1 %h",
               wb_valid, wb_byte_accessL, lv);
    end
    checks++;
    if (wb_reg_write !== (rw && kind == 1) || wb_load !== (kind == 1) ||
        wb_alu_out !== a || wb_rd_addr !== rd ||
        wb_pc_address_out !== pc || wb_u_imm !== ui) begin
      errors++;
      $display("FAIL wb_fwd got rw=%b ld=%b a=%h rd=%0d pc=%h ui=%h",
               wb_reg_write, wb_load, wb_alu_out, wb_rd_addr,
               wb_pc_address_out, wb_u_imm);
    end
    @(negedge clk);
    #1;
    checks++;
    if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL wb_once got v=%b req=%b want 0 0", wb_valid, dmem_req);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({dmem_req, stall, misaligned, wb_valid, wb_load, wb_jal, wb_jalr,
         wb_lui, wb_reg_write} !== 9'b0 ||
        {wb_alu_out, wb_byte_accessL, wb_pc_address_out, wb_u_imm} !== 128'b0 ||
        wb_rd_addr !== 5'b0) begin
      errors++;
      $display("FAIL reset_state got req=%b stall=%b v=%b a=%h",
               dmem_req, stall, wb_valid, wb_alu_out);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_passthrough();
    run_op(0, 3'd0, 32'h0000_1234, 32'h0, 32'h0, 0, 5'd5, 1'b1);
  endtask

  task automatic test_lb();
    run_op(1, 3'b000, 32'h0000_0102, 32'h0, 32'h80FF_7F01, 0, 5'd6, 1'b1);
    run_op(1, 3'b100, 32'h0000_0102, 32'h0, 32'h80FF_7F01, 0, 5'd7, 1'b1);
    run_op(1, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 0, 5'd8, 1'b1);
  endtask

  task automatic test_lhu_wait();
    run_op(1, 3'b101, 32'h0000_0206, 32'h0, 32'hBEEF_0000, 3, 5'd9, 1'b1);
  endtask

  task automatic test_sb();
    run_op(2, 3'b000, 32'h0000_0013, 32'h0000_00AB, 32'h0, 0, 5'd3, 1'b1);
  endtask

  task automatic test_misaligned();
    run_op(1, 3'b010, 32'h0000_0002, 32'h0, 32'h0, 0, 5'd4, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ex_valid = 1'b1;
    load = 1'b1;
    funct3 = 3'b010;
    alu_out = 32'h0000_0040;
    @(negedge clk);
    ex_valid = 1'b0;
    load = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %b want 1", dmem_req);
    end
    #1;
    rst = 1'b0;
    ex_valid = 1'b1;
    load = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got req=%b stall=%b v=%b want 0 0 0",
               dmem_req, stall, wb_valid);
    end
    @(negedge clk);
    ex_valid = 1'b0;
    load = 1'b0;
    rst = 1'b1;
    run_op(1, 3'b010, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 1, 5'd10, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 2);
      run_op(k, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), 5'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lb();
    test_lhu_wait();
    test_sb();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
